// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared definitions for the hardwired control unit.
//   - opcode values (5-bit) for the instruction classes the sequencer executes
//   - sequencer state encoding (RST, T0-T6, HALT, WAIT)
//   - IR field positions
//   - control vector struct produced by cu_output_decode
//   - op_class(): groups opcodes by the execute sequence they share
package cpu_defs_pkg;

  localparam int OPC_W   = 5;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_WAIT
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_MULDIV, CL_UNARY, CL_HALT
  } op_class_t;

  typedef struct packed {
    logic             pcout;
    logic             zhighout;
    logic             zlowout;
    logic             mdrout;
    logic             hiout;
    logic             loout;
    logic             pcin;
    logic             marin;
    logic             mdrin;
    logic             irin;
    logic             yin;
    logic             zin;
    logic             hiin;
    logic             loin;
    logic             incpc;
    logic             read;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             rin;
    logic             rout;
    logic [OPC_W-1:0] alu_op;
    logic             run;
  } ctrl_t;

  // Unknown opcodes fall into CL_NOP so they retire after T3.
  function automatic op_class_t op_class(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  return CL_ALU;
      OP_MUL, OP_DIV:                   return CL_MULDIV;
      OP_NEG, OP_NOT:                   return CL_UNARY;
      OP_HALT:                          return CL_HALT;
      default:                          return CL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cu_output_decode.sv
// cu_output_decode: combinational Moore decode of sequencer state plus
// opcode into the full datapath control vector.
//   i_state    : current sequencer state
//   i_opcode   : IR[31:27]
//   i_t1_first : high only in the first cycle of a T1 stretch (gates PCin)
//   o_ctrl     : control strobes, alu_op and run
module cu_output_decode
  import cpu_defs_pkg::*;
(
  input  state_t           i_state,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_t1_first,
  output ctrl_t            o_ctrl
);

  op_class_t w_cls;

  always_comb begin
    o_ctrl     = '0;
    w_cls      = op_class(i_opcode);
    o_ctrl.run = (i_state != S_RST) && (i_state != S_HALT);
    case (i_state)
      S_T0: begin
        // alu_op stays 0 here: IncPC alone selects the increment.
        o_ctrl.pcout = 1'b1;
        o_ctrl.marin = 1'b1;
        o_ctrl.incpc = 1'b1;
        o_ctrl.zin   = 1'b1;
      end
      S_T1: begin
        o_ctrl.zlowout = 1'b1;
        o_ctrl.pcin    = i_t1_first;
        o_ctrl.read    = 1'b1;
        o_ctrl.mdrin   = 1'b1;
      end
      S_T2: begin
        o_ctrl.mdrout = 1'b1;
        o_ctrl.irin   = 1'b1;
      end
      S_T3: begin
        case (w_cls)
          CL_ALU: begin
            o_ctrl.grb  = 1'b1;
            o_ctrl.rout = 1'b1;
            o_ctrl.yin  = 1'b1;
          end
          CL_MULDIV: begin
            o_ctrl.gra  = 1'b1;
            o_ctrl.rout = 1'b1;
            o_ctrl.yin  = 1'b1;
          end
          CL_UNARY: begin
            o_ctrl.grb    = 1'b1;
            o_ctrl.rout   = 1'b1;
            o_ctrl.zin    = 1'b1;
            o_ctrl.alu_op = i_opcode;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (w_cls)
          CL_ALU: begin
            o_ctrl.grc    = 1'b1;
            o_ctrl.rout   = 1'b1;
            o_ctrl.zin    = 1'b1;
            o_ctrl.alu_op = i_opcode;
          end
          CL_MULDIV: begin
            o_ctrl.grb    = 1'b1;
            o_ctrl.rout   = 1'b1;
            o_ctrl.zin    = 1'b1;
            o_ctrl.alu_op = i_opcode;
          end
          CL_UNARY: begin
            o_ctrl.zlowout = 1'b1;
            o_ctrl.gra     = 1'b1;
            o_ctrl.rin     = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (w_cls)
          CL_ALU: begin
            o_ctrl.zlowout = 1'b1;
            o_ctrl.gra     = 1'b1;
            o_ctrl.rin     = 1'b1;
          end
          CL_MULDIV: begin
            o_ctrl.zlowout = 1'b1;
            o_ctrl.loin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        if (w_cls == CL_MULDIV) begin
          o_ctrl.zhighout = 1'b1;
          o_ctrl.hiin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: hardwired control sequencer for the datapath.
// Runs fetch (T0-T2) and execute (T3-T6) for R-format ALU/shift, mul/div,
// neg/not, nop and halt. Holds the state register, the memory-ready wait
// in T1 and the pending-stop flag; output decode lives in cu_output_decode.
//
// Optional build macro CU_SINGLE_STEP_EN: adds i_step and the WAIT state,
// which is entered at each instruction end in place of T0.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_clear      synchronous active-high reset
//   i_ir         instruction register (opcode = IR[31:27])
//   i_mem_ready  memory read data valid this cycle
//   i_stop       halt request, honoured at instruction boundary
//   i_step       (CU_SINGLE_STEP_EN only) release from WAIT
//   o_*out       bus drive strobes
//   o_*in        register load strobes
//   o_incpc, o_read, o_gra/grb/grc, o_rin, o_rout
//   o_alu_op     ALU operation code
//   o_run        high while executing
//
// state | meaning
// ------+------------------------------------------------
// RST   | after Clear, all outputs 0
// T0    | PC -> MAR, PC+1 -> Z
// T1    | memory read, Z -> PC (first cycle), waits for Mem_ready
// T2    | MDR -> IR
// T3-T6 | execute steps, chosen by opcode class
// HALT  | stopped, all outputs 0, left only by Clear
// WAIT  | single-step hold until Step (CU_SINGLE_STEP_EN only)
module alu_control_unit
  import cpu_defs_pkg::*;
#(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           i_clock,
  input  logic           i_clear,
  input  logic [IRW-1:0] i_ir,
  input  logic           i_mem_ready,
  input  logic           i_stop,
`ifdef CU_SINGLE_STEP_EN
  input  logic           i_step,
`endif
  output logic           o_pcout,
  output logic           o_zhighout,
  output logic           o_zlowout,
  output logic           o_mdrout,
  output logic           o_hiout,
  output logic           o_loout,
  output logic           o_pcin,
  output logic           o_marin,
  output logic           o_mdrin,
  output logic           o_irin,
  output logic           o_yin,
  output logic           o_zin,
  output logic           o_hiin,
  output logic           o_loin,
  output logic           o_incpc,
  output logic           o_read,
  output logic           o_gra,
  output logic           o_grb,
  output logic           o_grc,
  output logic           o_rin,
  output logic           o_rout,
  output logic [OPW-1:0] o_alu_op,
  output logic           o_run
);

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_end_next;
  logic             r_stop_pend;
  logic             r_t1_prev;
  logic [OPC_W-1:0] w_opcode;
  op_class_t        w_cls;
  ctrl_t            w_ctrl;
  logic             w_unused_ir;

  assign w_opcode    = i_ir[OPC_MSB:OPC_LSB];
  assign w_cls       = op_class(w_opcode);
  assign w_unused_ir = ^i_ir[OPC_LSB-1:0];

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state     <= S_RST;
      r_stop_pend <= 1'b0;
      r_t1_prev   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      // T1 is only ever entered from T0, so this marks the repeat cycles.
      r_t1_prev <= (r_state == S_T1);
      if (i_stop) r_stop_pend <= 1'b1;
    end
  end

  always_comb begin
    w_end_next = S_T0;
`ifdef CU_SINGLE_STEP_EN
    w_end_next = S_WAIT;
`endif
    if (r_stop_pend) w_end_next = S_HALT;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RST:  w_state_next = S_T0;
      S_T0:   w_state_next = S_T1;
      S_T1:   w_state_next = i_mem_ready ? S_T2 : S_T1;
      S_T2:   w_state_next = S_T3;
      S_T3: begin
        case (w_cls)
          CL_HALT: w_state_next = S_HALT;
          CL_NOP:  w_state_next = w_end_next;
          default: w_state_next = S_T4;
        endcase
      end
      S_T4:   w_state_next = (w_cls == CL_UNARY) ? w_end_next : S_T5;
      S_T5:   w_state_next = (w_cls == CL_MULDIV) ? S_T6 : w_end_next;
      S_T6:   w_state_next = w_end_next;
      S_HALT: w_state_next = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_WAIT: w_state_next = i_step ? S_T0 : S_WAIT;
`endif
      default: w_state_next = S_RST;
    endcase
  end

  cu_output_decode u_decode (
    .i_state    (r_state),
    .i_opcode   (w_opcode),
    .i_t1_first (~r_t1_prev),
    .o_ctrl     (w_ctrl)
  );

  assign o_pcout    = w_ctrl.pcout;
  assign o_zhighout = w_ctrl.zhighout;
  assign o_zlowout  = w_ctrl.zlowout;
  assign o_mdrout   = w_ctrl.mdrout;
  assign o_hiout    = w_ctrl.hiout;
  assign o_loout    = w_ctrl.loout;
  assign o_pcin     = w_ctrl.pcin;
  assign o_marin    = w_ctrl.marin;
  assign o_mdrin    = w_ctrl.mdrin;
  assign o_irin     = w_ctrl.irin;
  assign o_yin      = w_ctrl.yin;
  assign o_zin      = w_ctrl.zin;
  assign o_hiin     = w_ctrl.hiin;
  assign o_loin     = w_ctrl.loin;
  assign o_incpc    = w_ctrl.incpc;
  assign o_read     = w_ctrl.read;
  assign o_gra      = w_ctrl.gra;
  assign o_grb      = w_ctrl.grb;
  assign o_grc      = w_ctrl.grc;
  assign o_rin      = w_ctrl.rin;
  assign o_rout     = w_ctrl.rout;
  assign o_alu_op   = w_ctrl.alu_op;
  assign o_run      = w_ctrl.run;

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;

  localparam logic [26:0] RUN      = 27'd1;
  localparam logic [26:0] ROUT     = 27'd1 << 6;
  localparam logic [26:0] RIN      = 27'd1 << 7;
  localparam logic [26:0] GRC      = 27'd1 << 8;
  localparam logic [26:0] GRB      = 27'd1 << 9;
  localparam logic [26:0] GRA      = 27'd1 << 10;
  localparam logic [26:0] READ     = 27'd1 << 11;
  localparam logic [26:0] INCPC    = 27'd1 << 12;
  localparam logic [26:0] LOIN     = 27'd1 << 13;
  localparam logic [26:0] HIIN     = 27'd1 << 14;
  localparam logic [26:0] ZIN      = 27'd1 << 15;
  localparam logic [26:0] YIN      = 27'd1 << 16;
  localparam logic [26:0] IRIN     = 27'd1 << 17;
  localparam logic [26:0] MDRIN    = 27'd1 << 18;
  localparam logic [26:0] MARIN    = 27'd1 << 19;
  localparam logic [26:0] PCIN     = 27'd1 << 20;
  localparam logic [26:0] MDROUT   = 27'd1 << 23;
  localparam logic [26:0] ZLOWOUT  = 27'd1 << 24;
  localparam logic [26:0] ZHIGHOUT = 27'd1 << 25;
  localparam logic [26:0] PCOUT    = 27'd1 << 26;

  localparam logic [26:0] X_T0  = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [26:0] X_T1  = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [26:0] X_T1W = ZLOWOUT | READ | MDRIN | RUN;
  localparam logic [26:0] X_T2  = MDROUT | IRIN | RUN;
  localparam logic [26:0] X_WB  = ZLOWOUT | GRA | RIN | RUN;

  typedef struct {
    logic [31:0] ir;
    logic        clr;
    logic        mr;
    logic        stp;
    logic        stv;
    logic [26:0] exp;
    string       nm;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] cur_ir;
  int          total = 0;
  int          bad   = 0;
  int          n_fetch = 0;
  int          n_t1    = 0;
  int          seen_pcin = 0;
  int          seen_read = 0;

  logic        clk = 1'b0;
  logic        clear, mem_ready, stop;
  logic [31:0] ir;
`ifdef CU_SINGLE_STEP_EN
  logic        step;
`endif
  logic pcout, zhighout, zlowout, mdrout, hiout, loout, pcin, marin, mdrin, irin;
  logic yin, zin, hiin, loin, incpc, rd, gra, grb, grc, rin, rout, run;
  logic [4:0]  alu_op;
  logic [26:0] act;

  always #5 clk = ~clk;

  alu_control_unit dut (
    .i_clock(clk), .i_clear(clear), .i_ir(ir), .i_mem_ready(mem_ready), .i_stop(stop),
`ifdef CU_SINGLE_STEP_EN
    .i_step(step),
`endif
    .o_pcout(pcout), .o_zhighout(zhighout), .o_zlowout(zlowout), .o_mdrout(mdrout),
    .o_hiout(hiout), .o_loout(loout), .o_pcin(pcin), .o_marin(marin), .o_mdrin(mdrin),
    .o_irin(irin), .o_yin(yin), .o_zin(zin), .o_hiin(hiin), .o_loin(loin),
    .o_incpc(incpc), .o_read(rd), .o_gra(gra), .o_grb(grb), .o_grc(grc),
    .o_rin(rin), .o_rout(rout), .o_alu_op(alu_op), .o_run(run)
  );

  assign act = {pcout, zhighout, zlowout, mdrout, hiout, loout, pcin, marin, mdrin, irin,
                yin, zin, hiin, loin, incpc, rd, gra, grb, grc, rin, rout, alu_op, run};

  function automatic logic [26:0] opv(input logic [4:0] op);
    return {21'd0, op, 1'b0};
  endfunction

  task automatic chk(input logic [31:0] got, input logic [31:0] want,
                     input string nm, input int row);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%07h want=%07h", nm, row, got, want);
    end
  endtask

  task automatic rx(input logic [26:0] e, input string nm,
                    input logic clr, input logic mr, input logic stp, input logic stv);
    vec_t v;
    v.ir = cur_ir; v.clr = clr; v.mr = mr; v.stp = stp; v.stv = stv;
    v.exp = e; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic r(input logic [26:0] e, input string nm);
    rx(e, nm, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic fetch(input int n_wait);
    n_fetch++;
    n_t1 += (n_wait == 0) ? 1 : n_wait + 1;
    r(X_T0, "t0");
    if (n_wait == 0) begin
      r(X_T1, "t1");
    end else begin
      rx(X_T1, "t1_first", 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < n_wait; i++) rx(X_T1W, "t1_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      rx(X_T1W, "t1_ready", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    r(X_T2, "t2");
  endtask

  task automatic end_instr();
`ifdef CU_SINGLE_STEP_EN
    rx(RUN, "wait_step", 1'b0, 1'b1, 1'b0, 1'b1);
`endif
  endtask

  task automatic alu3(input logic [4:0] op);
    r(GRB | ROUT | YIN | RUN, "alu_t3");
    r(GRC | ROUT | ZIN | opv(op) | RUN, "alu_t4");
    r(X_WB, "alu_t5");
  endtask

  initial begin
    clear = 1'b1; mem_ready = 1'b1; stop = 1'b0; ir = 32'h0;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
`endif
    cur_ir = 32'h0;

    r(27'd0, "rst_state");
    cur_ir = 32'h28918000; fetch(0); alu3(5'b00101); end_instr();
    cur_ir = 32'h38918000; fetch(3); alu3(5'b00111); end_instr();
    cur_ir = 32'h79A00000; fetch(0);
    r(GRA | ROUT | YIN | RUN, "mul_t3");
    r(GRB | ROUT | ZIN | opv(5'b01111) | RUN, "mul_t4");
    r(ZLOWOUT | LOIN | RUN, "mul_t5");
    r(ZHIGHOUT | HIIN | RUN, "mul_t6");
    end_instr();
    cur_ir = 32'h88000000; fetch(0);
    r(GRB | ROUT | ZIN | opv(5'b10001) | RUN, "neg_t3");
    r(X_WB, "neg_t4");
    end_instr();
    cur_ir = 32'hD0000000; fetch(0);
    r(RUN, "nop_t3");
`ifdef CU_SINGLE_STEP_EN
    for (int i = 0; i < 3; i++) rx(RUN, "wait_hold", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    end_instr();
    cur_ir = 32'h00000000; fetch(0);
    r(RUN, "undef_t3");
    end_instr();
    cur_ir = 32'h18918000; fetch(0);
    r(GRB | ROUT | YIN | RUN, "stop_t3");
    rx(GRC | ROUT | ZIN | opv(5'b00011) | RUN, "stop_t4", 1'b0, 1'b1, 1'b1, 1'b0);
    r(X_WB, "stop_t5_rin");
    for (int i = 0; i < 3; i++) r(27'd0, "stop_halt");
    rx(27'd0, "halt_clear", 1'b1, 1'b1, 1'b0, 1'b0);
    r(27'd0, "clear_rst");
    cur_ir = 32'hD0000000; fetch(0);
    r(RUN, "nop2_t3");
    end_instr();
    cur_ir = 32'hD8000000; fetch(0);
    r(RUN, "halt_t3");
    for (int i = 0; i < 20; i++) r(27'd0, "halt_hold");
    rx(27'd0, "halt_clear2", 1'b1, 1'b1, 1'b0, 1'b0);
    r(27'd0, "clear_rst2");
    cur_ir = 32'h18918000; fetch(0);
    r(GRB | ROUT | YIN | RUN, "abort_t3");
    rx(GRC | ROUT | ZIN | opv(5'b00011) | RUN, "abort_t4", 1'b1, 1'b1, 1'b0, 1'b0);
    r(27'd0, "abort_rst");
    r(X_T0, "abort_t0");

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({5'd0, act}, 32'd0, "reset_outputs_zero", -1);

    foreach (vecs[k]) begin
      @(negedge clk);
      ir        = vecs[k].ir;
      clear     = vecs[k].clr;
      mem_ready = vecs[k].mr;
      stop      = vecs[k].stp;
`ifdef CU_SINGLE_STEP_EN
      step      = vecs[k].stv;
`endif
      #1;
      if (pcin === 1'b1) seen_pcin++;
      if (rd === 1'b1)   seen_read++;
      chk({5'd0, act}, {5'd0, vecs[k].exp}, vecs[k].nm, k);
    end

    chk(seen_read, n_t1, "t1_wait_expired_cycles", -1);
    chk(seen_pcin, n_fetch, "pcin_once_per_fetch", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
